// File: rtl/branch_hazard_ctrl.sv
// Stall/flush controller for the ID-stage branch resolution path of a 5-stage MIPS pipeline.
// Optional performance counters are enabled with `define BHU_PERF_CNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_RUN    | normal issue; hazards evaluated, flush on taken branch / jump
// ST_STALL  | extra stall cycles owed to a load feeding a branch; bubbles ID/EX
// ST_FREEZE | external hold; return state and cnt preserved until hold drops
module branch_hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       branch,
    input  logic       jump,
    input  logic       uses_rs,
    input  logic       uses_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       branch_taken,
    input  logic       reg_write_idex,
    input  logic       mem_read_idex,
    input  logic [4:0] writebackreg_idex,
    input  logic       reg_write_exmem,
    input  logic       mem_read_exmem,
    input  logic [4:0] writebackreg_exmem,
    input  logic       hold,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       flush_idex,
    output logic       flush_ifid,
    output logic       busy
`ifdef BHU_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    state_t     saved_state;
    state_t     saved_nxt;
    state_t     eff_state;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic [1:0] need_n;
    logic       match_idex;
    logic       match_exmem;
    logic       stall_int;
    logic       flush_idex_int;
    logic       flush_ifid_int;

    assign match_idex  = (writebackreg_idex != 5'd0) &&
                         ((uses_rs && (writebackreg_idex == rs)) ||
                          (uses_rt && (writebackreg_idex == rt)));
    assign match_exmem = (writebackreg_exmem != 5'd0) &&
                         ((uses_rs && (writebackreg_exmem == rs)) ||
                          (uses_rt && (writebackreg_exmem == rt)));

    // ALU results in EX/MEM are already reachable by the ID forwarding muxes,
    // so reg_write_exmem alone never costs a stall.
    always_comb begin
        need_n = 2'd0;
        if (branch && mem_read_idex && match_idex)
            need_n = 2'd2;
        else if (branch && reg_write_idex && !mem_read_idex && match_idex)
            need_n = 2'd1;
        else if (branch && mem_read_exmem && match_exmem)
            need_n = 2'd1;
        else if (!branch && mem_read_idex && match_idex)
            need_n = 2'd1;
    end

    // Once hold drops, FREEZE behaves as the saved state in that same cycle.
    assign eff_state = (state == ST_FREEZE) ? saved_state : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            saved_state <= ST_RUN;
            cnt         <= 2'd0;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_nxt;
            cnt         <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        saved_nxt = saved_state;
        cnt_nxt   = cnt;
        if (hold) begin
            state_nxt = ST_FREEZE;
            if (state != ST_FREEZE)
                saved_nxt = state;
        end else begin
            case (eff_state)
                ST_RUN: begin
                    if (need_n != 2'd0) begin
                        cnt_nxt   = need_n - 2'd1;
                        state_nxt = ((need_n - 2'd1) != 2'd0) ? ST_STALL : ST_RUN;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_STALL: begin
                    cnt_nxt   = cnt - 2'd1;
                    state_nxt = (cnt == 2'd1) ? ST_RUN : ST_STALL;
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    // A bubble is never inserted under hold: ID/EX is frozen, not advancing.
    always_comb begin
        stall_int      = 1'b0;
        flush_idex_int = 1'b0;
        flush_ifid_int = 1'b0;
        if (hold) begin
            stall_int = 1'b1;
        end else begin
            case (eff_state)
                ST_RUN: begin
                    if (need_n != 2'd0) begin
                        stall_int      = 1'b1;
                        flush_idex_int = 1'b1;
                    end else begin
                        flush_ifid_int = jump | (branch & branch_taken);
                    end
                end
                ST_STALL: begin
                    stall_int      = 1'b1;
                    flush_idex_int = 1'b1;
                end
                default: begin
                    stall_int = 1'b1;
                end
            endcase
        end
    end

    assign stall_pc   = stall_int & rst_n;
    assign stall_ifid = stall_int & rst_n;
    assign flush_idex = flush_idex_int & rst_n;
    assign flush_ifid = flush_ifid_int & rst_n;
    assign busy       = (state != ST_RUN) & rst_n;

`ifdef BHU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stall_int && !hold && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (flush_ifid_int && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed hazard scenarios plus
// randomized traffic checked against a stall-budget reference model.
module tb_branch_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       branch, jump, uses_rs, uses_rt;
    logic [4:0] rs, rt;
    logic       branch_taken;
    logic       reg_write_idex, mem_read_idex;
    logic [4:0] writebackreg_idex;
    logic       reg_write_exmem, mem_read_exmem;
    logic [4:0] writebackreg_exmem;
    logic       hold;
    logic       stall_pc, stall_ifid, flush_idex, flush_ifid, busy;
`ifdef BHU_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_count;
    int          m_stall_cycles, m_flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: forced stall cycles still owed, and whether last cycle was held
    int m_rem;
    bit m_prev_hold;

    branch_hazard_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch             (branch),
        .jump               (jump),
        .uses_rs            (uses_rs),
        .uses_rt            (uses_rt),
        .rs                 (rs),
        .rt                 (rt),
        .branch_taken       (branch_taken),
        .reg_write_idex     (reg_write_idex),
        .mem_read_idex      (mem_read_idex),
        .writebackreg_idex  (writebackreg_idex),
        .reg_write_exmem    (reg_write_exmem),
        .mem_read_exmem     (mem_read_exmem),
        .writebackreg_exmem (writebackreg_exmem),
        .hold               (hold),
        .stall_pc           (stall_pc),
        .stall_ifid         (stall_ifid),
        .flush_idex         (flush_idex),
        .flush_ifid         (flush_ifid),
        .busy               (busy)
`ifdef BHU_PERF_CNT_EN
        ,
        .stall_cycles       (stall_cycles),
        .flush_count        (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {stall_pc, stall_ifid, flush_idex, flush_ifid, busy};
    endfunction

    task automatic clear_inputs();
        branch = 0; jump = 0; uses_rs = 0; uses_rt = 0; rs = 0; rt = 0;
        branch_taken = 0; reg_write_idex = 0; mem_read_idex = 0; writebackreg_idex = 0;
        reg_write_exmem = 0; mem_read_exmem = 0; writebackreg_exmem = 0; hold = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        m_rem = 0;
        m_prev_hold = 0;
`ifdef BHU_PERF_CNT_EN
        m_stall_cycles = 0;
        m_flush_count  = 0;
`endif
    endtask

    // Drive a branch whose rs/rt read $2/$3 with a load to $2 sitting in EX.
    task automatic load_then_beq();
        clear_inputs();
        branch = 1; uses_rs = 1; uses_rt = 1; rs = 5'd2; rt = 5'd3;
        reg_write_idex = 1; mem_read_idex = 1; writebackreg_idex = 5'd2;
    endtask

    // Pipeline advance after a bubble: the load moves to MEM, ID/EX is empty.
    task automatic load_moves_to_mem();
        reg_write_idex = 0; mem_read_idex = 0; writebackreg_idex = 0;
        reg_write_exmem = 1; mem_read_exmem = 1; writebackreg_exmem = 5'd2;
    endtask

    function automatic bit hit(input logic [4:0] d);
        return (d != 0) && ((uses_rs && d == rs) || (uses_rt && d == rt));
    endfunction

    function automatic int model_n();
        if (branch && mem_read_idex && hit(writebackreg_idex)) return 2;
        if (branch && reg_write_idex && !mem_read_idex && hit(writebackreg_idex)) return 1;
        if (branch && mem_read_exmem && hit(writebackreg_exmem)) return 1;
        if (!branch && mem_read_idex && hit(writebackreg_idex)) return 1;
        return 0;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        load_then_beq();
        rst_n = 0;
        #1;
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp 00000", outs());
        end
        do_reset();
        #1;
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_idle got %b exp 00000", outs());
        end
    endtask

    task automatic test_load_branch();
        logic [4:0] exp [3] = '{5'b11100, 5'b11101, 5'b00010};
        do_reset();
        load_then_beq();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) load_moves_to_mem();
            if (c == 2) begin
                mem_read_exmem = 0; reg_write_exmem = 0; writebackreg_exmem = 0;
                branch_taken = 1;
            end
            #1;
            n_checks++;
            if (outs() !== exp[c]) begin
                n_fail++;
                $display("FAIL load_branch cycle %0d got %b exp %b", c, outs(), exp[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_branch();
        do_reset();
        branch = 1; uses_rs = 1; uses_rt = 1; rs = 5'd4; rt = 5'd0;
        reg_write_idex = 1; writebackreg_idex = 5'd4;
        #1;
        n_checks++;
        if (outs() !== 5'b11100) begin
            n_fail++;
            $display("FAIL alu_branch stall got %b exp 11100", outs());
        end
        @(negedge clk);
        reg_write_idex = 0; writebackreg_idex = 0;
        reg_write_exmem = 1; writebackreg_exmem = 5'd4; branch_taken = 1;
        #1;
        n_checks++;
        if (outs() !== 5'b00010) begin
            n_fail++;
            $display("FAIL alu_branch resolve got %b exp 00010", outs());
        end
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        do_reset();
        branch = 1; uses_rs = 1; uses_rt = 1; rs = 0; rt = 0;
        reg_write_idex = 1; writebackreg_idex = 0; branch_taken = 1;
        #1;
        n_checks++;
        if (outs() !== 5'b00010) begin
            n_fail++;
            $display("FAIL zero_reg taken got %b exp 00010", outs());
        end
        @(negedge clk);
        branch_taken = 0;
        #1;
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL zero_reg not_taken got %b exp 00000", outs());
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        do_reset();
        uses_rs = 1; uses_rt = 1; rs = 5'd1; rt = 5'd5;
        reg_write_idex = 1; mem_read_idex = 1; writebackreg_idex = 5'd5;
        #1;
        n_checks++;
        if (outs() !== 5'b11100) begin
            n_fail++;
            $display("FAIL load_use stall got %b exp 11100", outs());
        end
        @(negedge clk);
        uses_rt = 0;
        #1;
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL load_use no_rt got %b exp 00000", outs());
        end
        @(negedge clk);
        // load already in MEM: branch still waits one cycle
        clear_inputs();
        branch = 1; uses_rs = 1; rs = 5'd7;
        mem_read_exmem = 1; reg_write_exmem = 1; writebackreg_exmem = 5'd7;
        #1;
        n_checks++;
        if (outs() !== 5'b11100) begin
            n_fail++;
            $display("FAIL load_mem_branch got %b exp 11100", outs());
        end
        @(negedge clk);
        clear_inputs();
        jump = 1;
        #1;
        n_checks++;
        if (outs() !== 5'b00010) begin
            n_fail++;
            $display("FAIL jump_flush got %b exp 00010", outs());
        end
        @(negedge clk);
    endtask

    task automatic test_hold_in_stall();
        logic [4:0] exp [6] = '{5'b11100, 5'b11001, 5'b11001, 5'b11001, 5'b11101, 5'b00000};
        do_reset();
        load_then_beq();
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin load_moves_to_mem(); hold = 1; end
            if (c == 4) hold = 0;
            if (c == 5) clear_inputs();
            #1;
            n_checks++;
            if (outs() !== exp[c]) begin
                n_fail++;
                $display("FAIL hold_in_stall cycle %0d got %b exp %b", c, outs(), exp[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_with_hazard();
        logic [4:0] exp [4] = '{5'b11000, 5'b11101, 5'b11101, 5'b00000};
        do_reset();
        load_then_beq();
        hold = 1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) hold = 0;
            if (c == 2) load_moves_to_mem();
            if (c == 3) clear_inputs();
            #1;
            n_checks++;
            if (outs() !== exp[c]) begin
                n_fail++;
                $display("FAIL hold_with_hazard cycle %0d got %b exp %b", c, outs(), exp[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load_then_beq();
        @(negedge clk);
        load_moves_to_mem();
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stall_busy got %b exp 1", busy);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_mid_stall got %b exp 00000", outs());
        end
`ifdef BHU_PERF_CNT_EN
        n_checks++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_perf got %0d/%0d exp 0/0", stall_cycles, flush_count);
        end
`endif
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        #1;
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL after_reset_residual got %b exp 00000", outs());
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [4:0] exp;
        int n;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            branch = ($urandom_range(0, 2) == 0);
            jump = !branch && ($urandom_range(0, 5) == 0);
            uses_rs = $urandom_range(0, 1); uses_rt = $urandom_range(0, 1);
            rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
            branch_taken = $urandom_range(0, 1);
            reg_write_idex = $urandom_range(0, 1); mem_read_idex = $urandom_range(0, 1);
            writebackreg_idex = 5'($urandom_range(0, 3));
            reg_write_exmem = $urandom_range(0, 1); mem_read_exmem = $urandom_range(0, 1);
            writebackreg_exmem = 5'($urandom_range(0, 3));
            hold = ($urandom_range(0, 6) == 0);
            #1;
            n = model_n();
            exp = 5'b00000;
            exp[0] = (m_rem > 0) || m_prev_hold;
            if (hold) exp[4:3] = 2'b11;
            else if (m_rem > 0 || n > 0) exp[4:2] = 3'b111;
            else exp[1] = jump | (branch & branch_taken);
            n_checks++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d got %b exp %b", c, outs(), exp);
            end
`ifdef BHU_PERF_CNT_EN
            n_checks++;
            if (stall_cycles !== 16'(m_stall_cycles) || flush_count !== 16'(m_flush_count)) begin
                n_fail++;
                $display("FAIL random_perf cycle %0d got %0d/%0d exp %0d/%0d",
                         c, stall_cycles, flush_count, m_stall_cycles, m_flush_count);
            end
            if (exp[4] && !hold && m_stall_cycles < 16'hFFFF) m_stall_cycles++;
            if (exp[1] && m_flush_count < 16'hFFFF) m_flush_count++;
`endif
            if (hold) begin
                m_prev_hold = 1;
            end else begin
                m_prev_hold = 0;
                if (m_rem > 0) m_rem--;
                else if (n > 0) m_rem = n - 1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        m_rem = 0;
        m_prev_hold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_load_branch();
        test_alu_branch();
        test_zero_reg();
        test_load_use();
        test_hold_in_stall();
        test_hold_with_hazard();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
